// File: rtl/chebyshev_term_sequencer.sv
// Chebyshev term sequencer: holds c0..cORDER and streams (x, ck) pairs per sample.
// Ports: clock/resetn, coeff write port, x valid/ready input, cheb_* term stream, busy.
module chebyshev_term_sequencer #(
  parameter int WL    = 4,
  parameter int CL    = 4,
  parameter int ORDER = 3,
  parameter int AW    = 2,
  parameter int GAP   = 2
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          coeff_we,
  input  logic [AW-1:0] coeff_waddr,
  input  logic [CL-1:0] coeff_wdata,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [WL-1:0] x_data,
  output logic [WL-1:0] cheb_x,
  output logic [CL-1:0] cheb_coeff,
  output logic          cheb_valid,
  output logic          cheb_first,
  output logic          cheb_last,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  localparam int MX = (ORDER > GAP) ? ORDER : GAP;
  localparam int CW = (MX < 1) ? 1 : $clog2(MX + 1);
  localparam logic [CW-1:0] TLAST = CW'(ORDER);
  localparam logic [CW-1:0] GLAST = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [WL-1:0]   xreg, xreg_n;
  logic [CL-1:0]   coeff [0:ORDER];
  logic [CL-1:0]   csel;
  logic [WL-1:0]   ox_n;
  logic [CL-1:0]   oc_n;
  logic            ov_n, of_n, ol_n;
  logic            accept, wr;

  assign x_ready = (state == IDLE) && resetn;
  assign busy    = (state != IDLE);
  assign accept  = x_valid && x_ready;
  // Writes only between bursts so a burst never mixes coefficient sets.
  assign wr      = coeff_we && (state == IDLE) && !accept;

  always_comb begin
    csel = '0;
    for (int i = 0; i <= ORDER; i++) begin
      if (cnt == CW'(i)) csel = coeff[i];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    xreg_n  = xreg;
    ox_n    = '0;
    oc_n    = '0;
    ov_n    = 1'b0;
    of_n    = 1'b0;
    ol_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          xreg_n = x_data;
          ox_n   = x_data;
          oc_n   = coeff[0];
          ov_n   = 1'b1;
          of_n   = 1'b1;
          if (ORDER == 0) begin
            ol_n    = 1'b1;
            cnt_n   = '0;
            state_n = (GAP > 0) ? FLUSH : IDLE;
          end else begin
            cnt_n   = ONE;
            state_n = STREAM;
          end
        end
      end
      STREAM: begin
        ox_n = xreg;
        oc_n = csel;
        ov_n = 1'b1;
        if (cnt == TLAST) begin
          ol_n    = 1'b1;
          cnt_n   = '0;
          state_n = (GAP > 0) ? FLUSH : IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      FLUSH: begin
        if (cnt == GLAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      xreg       <= '0;
      cheb_x     <= '0;
      cheb_coeff <= '0;
      cheb_valid <= 1'b0;
      cheb_first <= 1'b0;
      cheb_last  <= 1'b0;
      for (int i = 0; i <= ORDER; i++) coeff[i] <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      xreg       <= xreg_n;
      cheb_x     <= ox_n;
      cheb_coeff <= oc_n;
      cheb_valid <= ov_n;
      cheb_first <= of_n;
      cheb_last  <= ol_n;
      // Out-of-range addresses match no entry and are dropped.
      if (wr) begin
        for (int i = 0; i <= ORDER; i++) begin
          if (coeff_waddr == AW'(i)) coeff[i] <= coeff_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_chebyshev_term_sequencer.sv
// Bench for chebyshev_term_sequencer: queued expected terms vs DUT stream.
// Directed coefficient load and burst, then randomized traffic with resets.
module tb_chebyshev_term_sequencer;

  localparam int WL    = 4;
  localparam int CL    = 4;
  localparam int ORDER = 3;
  localparam int AW    = 2;
  localparam int GAP   = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          coeff_we;
  logic [AW-1:0] coeff_waddr;
  logic [CL-1:0] coeff_wdata;
  logic          x_valid;
  logic          x_ready;
  logic [WL-1:0] x_data;
  logic [WL-1:0] cheb_x;
  logic [CL-1:0] cheb_coeff;
  logic          cheb_valid;
  logic          cheb_first;
  logic          cheb_last;
  logic          busy;

  chebyshev_term_sequencer #(
    .WL(WL), .CL(CL), .ORDER(ORDER), .AW(AW), .GAP(GAP)
  ) dut (
    .clock(clk),
    .resetn(resetn),
    .coeff_we(coeff_we),
    .coeff_waddr(coeff_waddr),
    .coeff_wdata(coeff_wdata),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x_data(x_data),
    .cheb_x(cheb_x),
    .cheb_coeff(cheb_coeff),
    .cheb_valid(cheb_valid),
    .cheb_first(cheb_first),
    .cheb_last(cheb_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int c;
    int f;
    int l;
    int due;
  } exp_t;

  exp_t q[$];
  int   cmodel [0:ORDER];
  int   blocked = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference: each accepted sample yields ORDER+1 terms on the following
  // edges, and the input is blocked for ORDER+GAP cycles afterwards.
  task automatic model_edge();
    bit acc;
    if (!resetn) begin
      blocked = 0;
      q.delete();
      for (int k = 0; k <= ORDER; k++) cmodel[k] = 0;
    end else begin
      acc = x_valid && (blocked == 0);
      if (coeff_we && blocked == 0 && !acc && int'(coeff_waddr) <= ORDER)
        cmodel[coeff_waddr] = int'($signed(coeff_wdata));
      if (acc) begin
        for (int k = 0; k <= ORDER; k++) begin
          exp_t e;
          e.x   = int'($signed(x_data));
          e.c   = cmodel[k];
          e.f   = (k == 0) ? 1 : 0;
          e.l   = (k == ORDER) ? 1 : 0;
          e.due = cyc + k;
          q.push_back(e);
        end
        blocked = ORDER + GAP;
      end else if (blocked > 0) begin
        blocked--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    mon_on = 1;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("x_ready", int'(x_ready), (resetn && blocked == 0) ? 1 : 0);
      chk("busy", int'(busy), (blocked > 0) ? 1 : 0);
      if (cheb_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_term", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("term_cycle", cyc, e.due);
          chk("cheb_x", int'($signed(cheb_x)), e.x);
          chk("cheb_coeff", int'($signed(cheb_coeff)), e.c);
          chk("cheb_first", int'(cheb_first), e.f);
          chk("cheb_last", int'(cheb_last), e.l);
        end
      end else begin
        chk("idle_zero", int'({cheb_x, cheb_coeff, cheb_first, cheb_last}), 0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("missing_term", cyc, q[0].due - 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    resetn      = 1'b0;
    coeff_we    = 1'b0;
    coeff_waddr = '0;
    coeff_wdata = '0;
    x_valid     = 1'b0;
    x_data      = '0;
    repeat (2) step();
    resetn = 1'b1;

    for (int k = 0; k <= ORDER; k++) begin
      int vals [4] = '{2, 3, 1, 15};
      coeff_we    = 1'b1;
      coeff_waddr = AW'(k);
      coeff_wdata = CL'(vals[k]);
      step();
    end
    coeff_we = 1'b0;
    x_valid  = 1'b1;
    x_data   = 4'b0100;
    step();
    x_valid = 1'b0;
    repeat (2) step();
    coeff_we    = 1'b1;
    coeff_waddr = 2'd1;
    coeff_wdata = 4'b0111;
    step();
    coeff_we = 1'b0;
    repeat (6) step();

    x_valid = 1'b1;
    x_data  = 4'b0110;
    step();
    x_data  = 4'b0101;
    repeat (12) step();
    x_valid = 1'b0;
    repeat (4) step();

    for (int n = 0; n < 3000; n++) begin
      resetn      = ($urandom_range(0, 59) != 0);
      x_valid     = ($urandom_range(0, 2) != 0);
      x_data      = WL'($urandom);
      coeff_we    = ($urandom_range(0, 3) == 0);
      coeff_waddr = AW'($urandom);
      coeff_wdata = CL'($urandom);
      step();
    end

    resetn   = 1'b1;
    x_valid  = 1'b0;
    coeff_we = 1'b0;
    repeat (12) step();
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
